gray_step_sequencer: RTL and testbench

Command-driven controller that sequences an up/down Gray-code position counter: accepts a step count, direction and pacing divider via valid/ready, then advances the counter one code per paced interval until done or aborted. Drives stepper/encoder-emulation outputs and position bookkeeping for downstream logic. Binary and Gray views of the position are held side by side; the Gray view is always the registered conversion of the binary view.

---
 rtl/gray_seq_pkg.sv | 21 ++
 rtl/gray_step_core.sv | 42 ++++
 rtl/gray_step_sequencer.sv | 100 ++++++++++
 tb/tb_gray_step_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_seq_pkg.sv
// Shared types and helpers for the Gray-code step sequencer.
// The Gray view of the position is always derived from the binary view through bin2gray.
package gray_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Wide enough for any practical SIZE; callers cast the result down to their own width.
  localparam int unsigned GRAY_MAX_W = 32;

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_step_core.sv
// Position register pair: binary counter plus its registered Gray conversion.
// Both registers update on the same edge, so the Gray view never lags the binary view.
module gray_step_core
  import gray_seq_pkg::*;
#(
  parameter int unsigned SIZE = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_step_en,
  input  logic            i_dir,
  output logic [SIZE-1:0] o_binn,
  output logic [SIZE-1:0] o_gray
);

  logic [SIZE-1:0] r_binn;
  logic [SIZE-1:0] r_gray;
  logic [SIZE-1:0] w_binn_next;

  // Wraps modulo 2^SIZE in both directions.
  always_comb begin
    if (i_dir == DIR_UP) begin
      w_binn_next = r_binn + SIZE'(1);
    end else begin
      w_binn_next = r_binn - SIZE'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_binn <= '0;
      r_gray <= '0;
    end else if (i_step_en) begin
      r_binn <= w_binn_next;
      r_gray <= SIZE'(bin2gray(GRAY_MAX_W'(w_binn_next)));
    end
  end

  assign o_binn = r_binn;
  assign o_gray = r_gray;

endmodule

// File: rtl/gray_step_sequencer.sv
// Command-driven Gray-code step sequencer: accepts steps/dir/div, then paces the position
// counter one code per (div+1) cycles until the count is exhausted or the command is aborted.
module gray_step_sequencer
  import gray_seq_pkg::*;
#(
  parameter int unsigned SIZE  = 4,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned DIV_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [CNT_W-1:0] i_cmd_steps,
  input  logic             i_cmd_dir,
  input  logic [DIV_W-1:0] i_cmd_div,
  input  logic             i_abort,
  output logic             o_busy,
  output logic             o_step,
  output logic             o_done,
  output logic             o_aborted,
  output logic [CNT_W-1:0] o_remaining,
  output logic [SIZE-1:0]  o_count_gray,
  output logic [SIZE-1:0]  o_count_binn
);

  state_e           r_state;
  logic [CNT_W-1:0] r_remaining;
  logic [DIV_W-1:0] r_pace;
  logic [DIV_W-1:0] r_div;
  logic             r_dir;
  logic             r_step;
  logic             r_aborted;
  logic             w_step_en;

  // Abort outranks a due step on the same edge.
  assign w_step_en = (r_state == RUN) && !i_abort && (r_pace == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_pace      <= '0;
      r_div       <= '0;
      r_dir       <= DIR_DN;
      r_step      <= 1'b0;
      r_aborted   <= 1'b0;
    end else begin
      r_step <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (i_cmd_valid) begin
            r_remaining <= i_cmd_steps;
            r_pace      <= i_cmd_div;
            r_div       <= i_cmd_div;
            r_dir       <= i_cmd_dir;
            r_aborted   <= 1'b0;
            r_state     <= (i_cmd_steps == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (i_abort) begin
            r_aborted <= 1'b1;
            r_state   <= DONE;
          end else if (r_pace == '0) begin
            r_step      <= 1'b1;
            r_pace      <= r_div;
            r_remaining <= r_remaining - CNT_W'(1);
            if (r_remaining == CNT_W'(1)) begin
              r_state <= DONE;
            end
          end else begin
            r_pace <= r_pace - DIV_W'(1);
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  gray_step_core #(
    .SIZE(SIZE)
  ) u_core (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_step_en(w_step_en),
    .i_dir    (r_dir),
    .o_binn   (o_count_binn),
    .o_gray   (o_count_gray)
  );

  assign o_cmd_ready = (r_state == IDLE);
  assign o_busy      = (r_state == RUN);
  assign o_done      = (r_state == DONE);
  assign o_step      = r_step;
  assign o_aborted   = r_aborted;
  assign o_remaining = r_remaining;

endmodule

// File: tb/tb_gray_step_sequencer.sv
// Scoreboard bench: each command pushes its expected step/done events; a negedge monitor
// pops and compares them whenever the sequencer pulses o_step or o_done.
module tb_gray_step_sequencer;

  localparam int SIZE  = 4;
  localparam int CNT_W = 16;
  localparam int DIV_W = 8;
  localparam int MOD   = 1 << SIZE;

  logic             clk = 1'b0;
  logic             i_rst;
  logic             i_cmd_valid;
  logic             o_cmd_ready;
  logic [CNT_W-1:0] i_cmd_steps;
  logic             i_cmd_dir;
  logic [DIV_W-1:0] i_cmd_div;
  logic             i_abort;
  logic             o_busy;
  logic             o_step;
  logic             o_done;
  logic             o_aborted;
  logic [CNT_W-1:0] o_remaining;
  logic [SIZE-1:0]  o_count_gray;
  logic [SIZE-1:0]  o_count_binn;

  gray_step_sequencer #(
    .SIZE (SIZE),
    .CNT_W(CNT_W),
    .DIV_W(DIV_W)
  ) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_cmd_valid (i_cmd_valid),
    .o_cmd_ready (o_cmd_ready),
    .i_cmd_steps (i_cmd_steps),
    .i_cmd_dir   (i_cmd_dir),
    .i_cmd_div   (i_cmd_div),
    .i_abort     (i_abort),
    .o_busy      (o_busy),
    .o_step      (o_step),
    .o_done      (o_done),
    .o_aborted   (o_aborted),
    .o_remaining (o_remaining),
    .o_count_gray(o_count_gray),
    .o_count_binn(o_count_binn)
  );

  always #5 clk = ~clk;

  // Number of rising edges so far; at a negedge it names the edge just taken.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int binn;
    int rem;
    bit aborted;
  } exp_t;

  exp_t step_q[$];
  exp_t done_q[$];

  int   n_checks = 0;
  int   n_pass   = 0;
  int   pos      = 0;
  bit   exp_ab   = 1'b0;
  logic [SIZE-1:0] last_gray = '0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
  endtask

  function automatic int to_gray(input int b);
    int g = 0;
    // Reflected code built from the definition: bit i flips where binary bits i and i+1 differ.
    for (int i = 0; i < SIZE; i++) begin
      if (((b >> i) & 1) != ((b >> (i + 1)) & 1)) g += (1 << i);
    end
    return g;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (o_step) begin
      if (step_q.size() == 0) begin
        chk("unexpected_step", 1, 0);
      end else begin
        e = step_q.pop_front();
        chk("step_edge", cyc, e.cyc);
        chk("step_binn", o_count_binn, e.binn);
        chk("step_gray", o_count_gray, to_gray(e.binn));
        chk("step_remaining", o_remaining, e.rem);
        chk("gray_one_bit_change", $countones(o_count_gray ^ last_gray), 1);
      end
    end
    if (o_done) begin
      if (done_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = done_q.pop_front();
        chk("done_edge", cyc, e.cyc);
        chk("done_aborted", o_aborted, e.aborted);
        chk("done_remaining", o_remaining, e.rem);
        chk("done_binn", o_count_binn, e.binn);
        chk("done_ready_low", o_cmd_ready, 0);
      end
    end
    last_gray = o_count_gray;
  end

  // Offers one command; returns at the negedge after the accepting edge k (cyc == k).
  // abort_m >= 0 raises i_abort for the edge right after the abort_m-th step edge.
  task automatic issue(input int steps, input bit dir, input int div, input int abort_m,
                       output int k);
    int   guard = 0;
    int   performed;
    int   p;
    int   ea;
    exp_t e;
    @(negedge clk);
    while (!o_cmd_ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    k = cyc + 1;
    if (!o_cmd_ready) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    chk("aborted_sticky", o_aborted, exp_ab);
    i_cmd_valid = 1'b1;
    i_cmd_steps = CNT_W'(steps);
    i_cmd_dir   = dir;
    i_cmd_div   = DIV_W'(div);
    i_abort     = 1'($urandom % 2);  // ignored while idle
    performed   = (abort_m >= 0) ? abort_m : steps;
    ea          = k + abort_m * (div + 1) + 1;
    p           = pos;
    for (int n = 1; n <= performed; n++) begin
      p = dir ? (p + 1) % MOD : (p + MOD - 1) % MOD;
      e.cyc = k + n * (div + 1);
      e.binn = p;
      e.rem = steps - n;
      e.aborted = 1'b0;
      step_q.push_back(e);
    end
    e.cyc     = (abort_m >= 0) ? ea : k + steps * (div + 1);
    e.binn    = p;
    e.rem     = steps - performed;
    e.aborted = (abort_m >= 0);
    done_q.push_back(e);
    pos    = p;
    exp_ab = (abort_m >= 0);
    @(posedge clk);
    #1;
    i_cmd_valid = 1'b0;
    i_abort     = 1'b0;
    i_cmd_steps = CNT_W'($urandom);
    i_cmd_dir   = 1'($urandom % 2);
    i_cmd_div   = DIV_W'($urandom);
    @(negedge clk);
    chk("accept_clears_aborted", o_aborted, 0);
    chk("accept_loads_remaining", o_remaining, steps);
    if (abort_m >= 0) begin
      while (cyc < ea - 1) begin
        @(posedge clk);
        #1;
      end
      i_abort = 1'b1;
      @(posedge clk);
      #1;
      i_abort = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time (edge %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int k;
    int p0;
    int n;
    int er;
    int steps;
    int div;
    int m;
    int guard;
    i_rst       = 1'b1;
    i_cmd_valid = 1'b0;
    i_cmd_steps = '0;
    i_cmd_dir   = 1'b0;
    i_cmd_div   = '0;
    i_abort     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", o_cmd_ready, 1);
    chk("reset_busy", o_busy, 0);
    chk("reset_done", o_done, 0);
    chk("reset_binn", o_count_binn, 0);
    chk("reset_gray", o_count_gray, 0);
    chk("reset_remaining", o_remaining, 0);
    i_rst = 1'b0;

    issue(3, 1'b1, 0, -1, k);   // gray 0001, 0011, 0010
    issue(3, 1'b0, 0, -1, k);   // back to 0
    issue(1, 1'b0, 0, -1, k);   // wrap down to 1111
    issue(16, 1'b1, 0, -1, k);  // full cycle, ends at 1111
    issue(2, 1'b1, 2, -1, k);   // steps at k+3, k+6
    issue(0, 1'b1, 5, -1, k);   // immediate done, no step
    issue(5, 1'b1, 1, 1, k);    // abort after first step
    issue(2, 1'b0, 0, -1, k);   // clears aborted

    // Reset mid-run when the position reads 0101, with a command pending on the reset edge.
    p0 = pos;
    n  = ((5 - p0 + MOD) % MOD) + 16;
    issue(40, 1'b1, 1, -1, k);
    er = k + n * 2 + 1;
    while (cyc < er - 1) @(negedge clk);
    chk("pre_reset_binn", o_count_binn, 5);
    i_rst       = 1'b1;
    i_cmd_valid = 1'b1;
    i_cmd_steps = CNT_W'(7);
    @(posedge clk);
    #1;
    step_q.delete();
    done_q.delete();
    pos    = 0;
    exp_ab = 1'b0;
    @(negedge clk);
    chk("mid_reset_binn", o_count_binn, 0);
    chk("mid_reset_gray", o_count_gray, 0);
    chk("mid_reset_remaining", o_remaining, 0);
    chk("mid_reset_step", o_step, 0);
    chk("mid_reset_done", o_done, 0);
    chk("mid_reset_aborted", o_aborted, 0);
    chk("mid_reset_busy", o_busy, 0);
    chk("mid_reset_ready", o_cmd_ready, 1);
    i_rst       = 1'b0;
    i_cmd_valid = 1'b0;

    for (int t = 0; t < 30; t++) begin
      steps = $urandom_range(20, 0);
      div   = $urandom_range(3, 0);
      m     = -1;
      if (steps > 0 && ($urandom % 4) == 0) m = $urandom_range(steps - 1, 0);
      issue(steps, 1'($urandom % 2), div, m, k);
    end

    guard = 0;
    @(negedge clk);
    while (!o_cmd_ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    chk("final_idle", o_cmd_ready, 1);
    repeat (3) @(negedge clk);
    chk("step_queue_drained", step_q.size(), 0);
    chk("done_queue_drained", done_q.size(), 0);
    chk("final_binn", o_count_binn, pos);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
